// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a length-prefixed little-endian image over UART and writes it into the instruction ROM
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ROM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        rom_we,
  output logic [31:0] rom_wraddr,
  output logic [31:0] rom_wdata,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(ROM_WORDS) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} ld_state_t;
  logic [1:0]    sync_q;
  rx_state_t     rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid, frame_err;
  ld_state_t     ld_q, ld_d;
  logic [1:0]    bi_q, bi_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wc_q, wc_d, asm_q, asm_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          active;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ld_q    <= HDR;
      bi_q    <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      asm_q   <= '0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ld_q    <= ld_d;
      bi_q    <= bi_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end
  // Start bit is re-checked at half a bit so a short low glitch yields no byte
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync_q[1]) rx_st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        rx_st_d = sync_q[1] ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {sync_q[1], sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        byte_valid = sync_q[1];
        frame_err  = !sync_q[1];
        rx_st_d    = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end
  assign active = (ld_q == HDR) || (ld_q == DATA);
  always_comb begin
    ld_d    = ld_q;
    bi_d    = bi_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    asm_d   = asm_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (active && frame_err) ld_d = ERR;
    else if (active && byte_valid) begin
      asm_d = {sh_q, asm_q[31:8]};
      bi_d  = bi_q + 1'b1;
      if (bi_q == 2'd3 && ld_q == HDR) begin
        wc_d  = asm_d;
        idx_d = '0;
        ld_d  = (asm_d == '0) ? DONE : (asm_d > 32'(ROM_WORDS)) ? ERR : DATA;
      end else if (bi_q == 2'd3) begin
        we_d    = 1'b1;
        waddr_d = BASE_ADDR + (32'(idx_q) << 2);
        wdata_d = asm_d;
        idx_d   = idx_q + 1'b1;
        ld_d    = (32'(idx_q) == wc_q - 32'd1) ? DONE : DATA;
      end
    end
  end
  assign rom_we     = we_q;
  assign rom_wraddr = waddr_q;
  assign rom_wdata  = wdata_q;
  assign cpu_hold   = ld_q != DONE;
  assign boot_done  = ld_q == DONE;
  assign boot_err   = ld_q == ERR;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized image loads checked against a frame-level model of the loader
module tb_uart_boot_loader;
  localparam int CPB = 4;
  localparam int RW  = 16;
  logic        clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic        rom_we, cpu_hold, boot_done, boot_err;
  logic [31:0] rom_wraddr, rom_wdata;
  int          checks = 0, errors = 0;
  logic [63:0] wq[$];
  logic [2:0]  hq[$];
  logic [7:0]  img[$];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ROM_WORDS(RW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rom_we(rom_we), .rom_wraddr(rom_wraddr),
    .rom_wdata(rom_wdata), .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && rom_we) begin
    wq.push_back({rom_wraddr, rom_wdata});
    hq.push_back({cpu_hold, boot_done, boot_err});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    hq.delete();
    @(negedge clk);
    chk("rst_we", 32'(rom_we), 0);
    chk("rst_addr", rom_wraddr, 0);
    chk("rst_data", rom_wdata, 0);
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(boot_done), 0);
    chk("rst_err", 32'(boot_err), 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  // Model: header gives n words; image accepted if n<=RW; a bad stop bit before
  // the image is consumed is an error, anything after completion is ignored.
  task automatic run(input logic [7:0] b[$], input int bad);
    logic [31:0] hdr, w;
    int n, cons, nw, avail;
    logic ed, ee;
    foreach (b[i]) send_byte(b[i], i != bad);
    repeat (10 * CPB) @(negedge clk);
    hdr = {b[3], b[2], b[1], b[0]};
    avail = (b.size() - 4) / 4;
    ed = 1'b0;
    ee = 1'b1;
    nw = 0;
    if (bad >= 0 && bad < 4) nw = 0;
    else if (hdr > RW) nw = 0;
    else begin
      n = int'(hdr);
      cons = 4 + 4 * n;
      if (bad >= 0 && bad < cons) nw = (bad - 4) / 4;
      else begin
        nw = avail < n ? avail : n;
        ed = b.size() >= cons;
        ee = 1'b0;
      end
    end
    chk("npulse", wq.size(), nw);
    for (int k = 0; k < nw && k < wq.size(); k++) begin
      w = {b[4*k+7], b[4*k+6], b[4*k+5], b[4*k+4]};
      chk("waddr", wq[k][63:32], 4 * k);
      chk("wdata", wq[k][31:0], w);
      chk("pulse_hold", 32'(hq[k][2]), (ed && k == nw - 1) ? 0 : 1);
      chk("pulse_done", 32'(hq[k][1]), (ed && k == nw - 1) ? 1 : 0);
      chk("pulse_err", 32'(hq[k][0]), 0);
    end
    chk("done", 32'(boot_done), 32'(ed));
    chk("err", 32'(boot_err), 32'(ee));
    chk("hold", 32'(cpu_hold), 32'(!ed));
    chk("addr_hold", rom_wraddr, nw > 0 ? 4 * (nw - 1) : 0);
    chk("data_hold", rom_wdata, nw > 0 ? {b[4*nw+3], b[4*nw+2], b[4*nw+1], b[4*nw]} : 0);
  endtask

  initial begin
    int n, bad, nd, ex;
    do_reset();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run(img, -1);
    do_reset();
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    run(img, -1);
    do_reset();
    img = '{8'h11, 8'h00, 8'h00, 8'h00};
    repeat (8) img.push_back(8'($urandom));
    run(img, -1);
    do_reset();
    img = '{8'h10, 8'h00, 8'h00, 8'h00};
    repeat (64) img.push_back(8'($urandom));
    run(img, -1);
    chk("last_addr", rom_wraddr, 32'h3C);
    do_reset();
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run(img, 6);
    do_reset();
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run(img, -1);
    do_reset();
    img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    foreach (img[i]) send_byte(img[i], 1'b1);
    repeat (10 * CPB) @(negedge clk);
    chk("mid_pulses", wq.size(), 1);
    chk("mid_hold", 32'(cpu_hold), 1);
    do_reset();
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hDE, 8'hFE, 8'hCA};
    run(img, -1);
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(0, 19);
      img = '{8'(n), 8'h00, 8'h00, 8'h00};
      nd = n > RW ? 2 : n;
      ex = $urandom_range(0, 2);
      repeat (4 * nd + ex) img.push_back(8'($urandom));
      bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
      run(img, bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
